// File: rtl/pc_seq_pkg.sv
// Shared state encoding and opcode map for the PC sequencer.
// Opcode constants assume a 4-bit opcode field.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_FETCH2 = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP       = 4'h0;
  localparam logic [3:0] OP_LAST_DATA = 4'hB;
  localparam logic [3:0] OP_JC        = 4'hC;
  localparam logic [3:0] OP_JZ        = 4'hD;
  localparam logic [3:0] OP_JMP       = 4'hE;
  localparam logic [3:0] OP_HLT       = 4'hF;

  function automatic logic is_jump(input logic [3:0] opc);
    return (opc == OP_JC) || (opc == OP_JZ) || (opc == OP_JMP);
  endfunction

endpackage

// File: rtl/pc_seq_branch_eval.sv
// Jump resolution: taken decision and {target_hi, low byte} target, purely combinational.
// Zero latency; no flow control (flags are sampled in the same cycle as the low byte).
module pc_seq_branch_eval
  import pc_seq_pkg::*;
#(
  parameter int PC_W    = 12,
  parameter int INSTR_W = 8,
  parameter int OPC_W   = 4
) (
  input  logic [OPC_W-1:0]        opc,
  input  logic                    flag_z,
  input  logic                    flag_c,
  input  logic [PC_W-INSTR_W-1:0] target_hi,
  input  logic [INSTR_W-1:0]      instr,
  output logic                    taken,
  output logic [PC_W-1:0]         target
);

  always_comb begin
    taken  = (opc == OP_JMP)
          || ((opc == OP_JC) && flag_c)
          || ((opc == OP_JZ) && flag_z);
    target = {target_hi, instr};
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute controller driving PC increment/load and a one-cycle execute strobe.
// 3 cycles per instruction (1-byte and 2-byte jumps alike); halt_req honoured only at EXEC/FETCH2 exit.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_W    = 12,
  parameter int INSTR_W = 8,
  parameter int OPC_W   = 4
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               start,
  input  logic               halt_req,
  input  logic [INSTR_W-1:0] instr,
  input  logic               flag_z,
  input  logic               flag_c,
  output logic               pc_en,
  output logic               pc_load,
  output logic [PC_W-1:0]    pc_load_val,
  output logic [INSTR_W-1:0] ir_out,
  output logic               exec_en,
  output logic               busy,
  output logic               halted
);

  localparam int TGT_HI_W = PC_W - INSTR_W;

  state_t                state_q, state_d;
  logic [TGT_HI_W-1:0]   target_hi_q;
  logic [OPC_W-1:0]      opc;
  logic                  taken;
  logic [PC_W-1:0]       target;

  assign opc = ir_out[INSTR_W-1 -: OPC_W];

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      ir_out      <= '0;
      target_hi_q <= '0;
    end else begin
      if (state_q == S_FETCH) begin
        ir_out <= instr;
      end
      // Byte0 of a jump carries the upper target bits below the opcode.
      if ((state_q == S_DECODE) && is_jump(opc)) begin
        target_hi_q <= ir_out[TGT_HI_W-1:0];
      end
    end
  end

  pc_seq_branch_eval #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .OPC_W   (OPC_W)
  ) u_branch_eval (
    .opc       (opc),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .target_hi (target_hi_q),
    .instr     (instr),
    .taken     (taken),
    .target    (target)
  );

  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = '0;
    exec_en     = 1'b0;
    busy        = 1'b0;
    halted      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        busy    = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        busy = 1'b1;
        if (opc <= OP_LAST_DATA) begin
          state_d = S_EXEC;
        end else if (is_jump(opc)) begin
          pc_en   = 1'b1;
          state_d = S_FETCH2;
        end else begin
          // Step past HLT so a resume continues with the next byte.
          pc_en   = 1'b1;
          state_d = S_HALT;
        end
      end
      S_EXEC: begin
        busy    = 1'b1;
        exec_en = (opc != OP_NOP);
        pc_en   = 1'b1;
        state_d = halt_req ? S_HALT : S_FETCH;
      end
      S_FETCH2: begin
        busy = 1'b1;
        if (taken) begin
          pc_load     = 1'b1;
          pc_load_val = target;
        end else begin
          pc_en = 1'b1;
        end
        state_d = halt_req ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (start) state_d = S_FETCH;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer with a behavioural ROM and PC counter.
// Stimulus queues expected events/snapshots; a negedge monitor pops and compares.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        reset, start, halt_req, flag_z, flag_c;
  logic [7:0]  instr;
  logic        pc_en, pc_load, exec_en, busy, halted;
  logic [11:0] pc_load_val;
  logic [7:0]  ir_out;

  logic [11:0] pc = '0;
  logic        pc_set = 1'b0;
  logic [11:0] pc_set_val = '0;
  logic [7:0]  rom [4096];

  int cyc = 0;
  int start_cyc = 0;
  int last_c = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        ex;
    logic        en;
    logic        ld;
    logic [11:0] val;
    logic [7:0]  ir;
    logic [11:0] pc;
    logic [7:0]  gap;
  } evt_t;

  typedef struct packed {
    logic [1:0]  kind;
    logic        busy;
    logic        halted;
    logic        en;
    logic        ld;
    logic        ex;
    logic        chk_val;
    logic [11:0] val;
    logic [7:0]  ir;
    logic [11:0] pc;
  } snap_t;

  evt_t  evq[$];
  string evn[$];
  snap_t sq[$];
  string sn[$];

  pc_sequencer #(.PC_W(12), .INSTR_W(8), .OPC_W(4)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .start       (start),
    .halt_req    (halt_req),
    .instr       (instr),
    .flag_z      (flag_z),
    .flag_c      (flag_c),
    .pc_en       (pc_en),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .ir_out      (ir_out),
    .exec_en     (exec_en),
    .busy        (busy),
    .halted      (halted)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Counter model: load beats increment.
  always @(posedge CLK) begin
    if (pc_set)       pc <= pc_set_val;
    else if (pc_load) pc <= pc_load_val;
    else if (pc_en)   pc <= pc + 12'd1;
  end

  assign instr = rom[pc];

  always @(negedge CLK) begin : monitor
    snap_t s;
    evt_t  e;
    string nm;
    int    refc;
    int    gap;
    if (sq.size() != 0) begin
      s  = sq.pop_front();
      nm = sn.pop_front();
      n_tests++;
      case (s.kind)
        2'd1: begin
          n_fail++;
          $display("FAIL %s: DUT never reached halted within the cycle budget", nm);
        end
        2'd2: begin
          if (evq.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected events never seen, want 0", nm, evq.size());
          end
        end
        default: begin
          if ({busy, halted, pc_en, pc_load, exec_en, ir_out, pc} !==
              {s.busy, s.halted, s.en, s.ld, s.ex, s.ir, s.pc} ||
              (s.chk_val && (pc_load_val !== s.val))) begin
            n_fail++;
            $display("FAIL %s: got busy=%0b halted=%0b en=%0b ld=%0b ex=%0b val=%h ir=%h pc=%h, want busy=%0b halted=%0b en=%0b ld=%0b ex=%0b val=%h ir=%h pc=%h",
                     nm, busy, halted, pc_en, pc_load, exec_en, pc_load_val, ir_out, pc,
                     s.busy, s.halted, s.en, s.ld, s.ex, s.val, s.ir, s.pc);
          end
        end
      endcase
    end
    if (!reset && (exec_en || pc_en || pc_load)) begin
      n_tests++;
      refc   = (start_cyc > last_c) ? start_cyc : last_c;
      gap    = cyc - refc;
      last_c = cyc;
      if (evq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got ex=%0b en=%0b ld=%0b ir=%h pc=%h, want no activity",
                 exec_en, pc_en, pc_load, ir_out, pc);
      end else begin
        e  = evq.pop_front();
        nm = evn.pop_front();
        if (exec_en !== e.ex || pc_en !== e.en || pc_load !== e.ld || ir_out !== e.ir ||
            pc !== e.pc || gap != int'(e.gap) || (e.ld && pc_load_val !== e.val)) begin
          n_fail++;
          $display("FAIL %s: got ex=%0b en=%0b ld=%0b val=%h ir=%h pc=%h gap=%0d, want ex=%0b en=%0b ld=%0b val=%h ir=%h pc=%h gap=%0d",
                   nm, exec_en, pc_en, pc_load, pc_load_val, ir_out, pc, gap,
                   e.ex, e.en, e.ld, e.val, e.ir, e.pc, e.gap);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_pc(input logic [11:0] a);
    pc_set     = 1'b1;
    pc_set_val = a;
    tick();
    pc_set     = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic ev(input logic ex, input logic en, input logic ld, input logic [11:0] val,
                    input logic [7:0] ir, input logic [11:0] pcv, input int gap, input string name);
    evt_t e;
    e = '{ex: ex, en: en, ld: ld, val: val, ir: ir, pc: pcv, gap: 8'(gap)};
    evq.push_back(e);
    evn.push_back(name);
  endtask

  task automatic snap(input logic b, input logic h, input logic en, input logic ld, input logic ex,
                      input logic chk, input logic [11:0] val, input logic [7:0] ir,
                      input logic [11:0] pcv, input string name);
    snap_t s;
    s = '{kind: 2'd0, busy: b, halted: h, en: en, ld: ld, ex: ex, chk_val: chk,
          val: val, ir: ir, pc: pcv};
    sq.push_back(s);
    sn.push_back(name);
  endtask

  task automatic push_kind(input logic [1:0] k, input string name);
    snap_t s;
    s      = '0;
    s.kind = k;
    sq.push_back(s);
    sn.push_back(name);
  endtask

  task automatic wait_halted(input string name);
    for (int k = 0; k < 40 && !halted; k++) tick();
    if (!halted) push_kind(2'd1, name);
  endtask

  task automatic halted_at(input logic [7:0] ir, input logic [11:0] pcv, input string name);
    snap(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, ir, pcv, name);
    tick();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; halt_req = 1'b0; flag_z = 1'b0; flag_c = 1'b0;
    for (int i = 0; i < 4096; i++) rom[i] = 8'hF0;
    rom[12'h000] = 8'h31; rom[12'h001] = 8'h00;
    rom[12'h010] = 8'hE4; rom[12'h011] = 8'h56;
    rom[12'h020] = 8'hF0; rom[12'h021] = 8'h00;
    rom[12'h030] = 8'hD1; rom[12'h031] = 8'h23;
    rom[12'h040] = 8'hC7; rom[12'h041] = 8'h89;
    rom[12'h050] = 8'h52;
    rom[12'h060] = 8'hE7; rom[12'h061] = 8'h00;

    tick(); tick();
    snap(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 8'h00, 12'h000, "reset_state");
    tick();
    reset = 1'b0;
    tick();
    snap(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 8'h00, 12'h000, "idle_no_start");
    tick();

    // Data op then NOP then HLT.
    ev(1, 1, 0, 12'h000, 8'h31, 12'h000, 2, "t1_exec_31");
    ev(0, 1, 0, 12'h000, 8'h00, 12'h001, 3, "t1_exec_nop");
    ev(0, 1, 0, 12'h000, 8'hF0, 12'h002, 2, "t1_hlt");
    do_start();
    wait_halted("t1_wait");
    halted_at(8'hF0, 12'h003, "t1_halted");

    // Unconditional jump.
    set_pc(12'h010);
    ev(0, 1, 0, 12'h000, 8'hE4, 12'h010, 1, "t2_decode");
    ev(0, 0, 1, 12'h456, 8'hE4, 12'h011, 1, "t2_fetch2_load");
    ev(0, 1, 0, 12'h000, 8'hF0, 12'h456, 2, "t2_hlt_at_target");
    do_start();
    wait_halted("t2_wait");
    halted_at(8'hF0, 12'h457, "t2_halted");

    // JZ not taken, carry set to catch flag mix-ups.
    flag_z = 1'b0; flag_c = 1'b1;
    set_pc(12'h030);
    ev(0, 1, 0, 12'h000, 8'hD1, 12'h030, 1, "t3_jz_decode");
    ev(0, 1, 0, 12'h000, 8'hD1, 12'h031, 1, "t3_jz_not_taken");
    ev(0, 1, 0, 12'h000, 8'hF0, 12'h032, 2, "t3_jz_fallthrough_hlt");
    do_start();
    wait_halted("t3_wait");
    halted_at(8'hF0, 12'h033, "t3_halted");

    // JZ taken.
    flag_z = 1'b1; flag_c = 1'b0;
    set_pc(12'h030);
    ev(0, 1, 0, 12'h000, 8'hD1, 12'h030, 1, "t3b_jz_decode");
    ev(0, 0, 1, 12'h123, 8'hD1, 12'h031, 1, "t3b_jz_taken");
    ev(0, 1, 0, 12'h000, 8'hF0, 12'h123, 2, "t3b_hlt_at_target");
    do_start();
    wait_halted("t3b_wait");
    halted_at(8'hF0, 12'h124, "t3b_halted");

    // JC taken, then JC not taken with zero set.
    flag_z = 1'b0; flag_c = 1'b1;
    set_pc(12'h040);
    ev(0, 1, 0, 12'h000, 8'hC7, 12'h040, 1, "t3c_jc_decode");
    ev(0, 0, 1, 12'h789, 8'hC7, 12'h041, 1, "t3c_jc_taken");
    ev(0, 1, 0, 12'h000, 8'hF0, 12'h789, 2, "t3c_hlt_at_target");
    do_start();
    wait_halted("t3c_wait");
    halted_at(8'hF0, 12'h78A, "t3c_halted");
    flag_z = 1'b1; flag_c = 1'b0;
    set_pc(12'h040);
    ev(0, 1, 0, 12'h000, 8'hC7, 12'h040, 1, "t3d_jc_decode");
    ev(0, 1, 0, 12'h000, 8'hC7, 12'h041, 1, "t3d_jc_not_taken");
    ev(0, 1, 0, 12'h000, 8'hF0, 12'h042, 2, "t3d_fallthrough_hlt");
    do_start();
    wait_halted("t3d_wait");
    halted_at(8'hF0, 12'h043, "t3d_halted");
    flag_z = 1'b0; flag_c = 1'b0;

    // HLT holds the PC until start, then resumes at the next byte.
    set_pc(12'h020);
    ev(0, 1, 0, 12'h000, 8'hF0, 12'h020, 1, "t4_hlt_decode");
    do_start();
    wait_halted("t4_wait");
    halted_at(8'hF0, 12'h021, "t4_halted");
    for (int k = 0; k < 5; k++) tick();
    halted_at(8'hF0, 12'h021, "t4_still_held");
    ev(0, 1, 0, 12'h000, 8'h00, 12'h021, 2, "t4_resume_nop");
    ev(0, 1, 0, 12'h000, 8'hF0, 12'h022, 2, "t4_resume_hlt");
    do_start();
    wait_halted("t4_resume_wait");
    halted_at(8'hF0, 12'h023, "t4_resume_halted");

    // halt_req during DECODE; start also high in EXEC, halt wins.
    set_pc(12'h050);
    ev(1, 1, 0, 12'h000, 8'h52, 12'h050, 2, "t5_exec_completes");
    do_start();
    tick();
    halt_req = 1'b1; start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    halted_at(8'h52, 12'h051, "t5_halt_wins");
    halted_at(8'h52, 12'h051, "t5_halt_req_ignored");
    halt_req = 1'b0;
    ev(0, 1, 0, 12'h000, 8'hF0, 12'h051, 1, "t5_resume_hlt");
    do_start();
    wait_halted("t5_wait");
    halted_at(8'hF0, 12'h052, "t5_halted");

    // Reset during FETCH2 of a taken JMP aborts the load.
    set_pc(12'h060);
    ev(0, 1, 0, 12'h000, 8'hE7, 12'h060, 1, "t6_decode");
    do_start();
    tick();
    tick();
    reset = 1'b1;
    snap(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 8'h00, 12'h061, "t6_reset_abort");
    tick();
    snap(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 8'h00, 12'h061, "t6_no_load");
    tick();
    reset = 1'b0;
    tick();
    ev(0, 1, 0, 12'h000, 8'h00, 12'h061, 2, "t6_resume_nop");
    ev(0, 1, 0, 12'h000, 8'hF0, 12'h062, 2, "t6_resume_hlt");
    do_start();
    wait_halted("t6_wait");
    halted_at(8'hF0, 12'h063, "t6_halted");

    push_kind(2'd2, "all_events_seen");
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch/decode/execute controller that drives the team's 12-bit program counter (enable, load and load-value inputs).
- Sits between the instruction ROM (its data output feeds instr) and the PC counter.
- Decides each cycle whether the PC increments, loads a jump target or holds.
- Emits one-cycle execute strobes to the datapath and implements two-byte conditional/unconditional jumps plus halt/resume.

Parameters:
- PC_W, 12, PC width; must equal (INSTR_W-OPC_W)+INSTR_W.
- INSTR_W, 8, ROM word width.
- OPC_W, 4, opcode field width, instr[INSTR_W-1 -: OPC_W].

Ports:
- CLK  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE.
- start  in  1  level/pulse; leaves IDLE or HALT.
- halt_req  in  1  external halt request, sampled at instruction boundaries.
- instr  in  INSTR_W  ROM word addressed by current PC.
- flag_z  in  1  ALU zero flag.
- flag_c  in  1  ALU carry flag.
- pc_en  out  1  PC increment enable.
- pc_load  out  1  PC parallel-load strobe; the counter gives load priority over increment.
- pc_load_val  out  PC_W  jump target.
- ir_out  out  INSTR_W  registered current instruction byte.
- exec_en  out  1  one-cycle datapath execute strobe.
- busy  out  1  high in FETCH/DECODE/EXEC/FETCH2.
- halted  out  1  high in HALT.

Behaviour:
- Reset is decided: reset, asynchronous, active-high; clock CLK.
- While reset=1: state=IDLE, ir_out=0, target-high register=0, every output 0 (pc_load_val=0).
- Control outputs are a combinational decode of the registered state, ir_out and instr, and the flags.
- pc_en and pc_load are never both 1.

Opcodes:
- 0x0 NOP.
- 0x1-0xB data ops.
- 0xC JC.
- 0xD JZ.
- 0xE JMP.
- 0xF HLT.
- Jumps are two bytes: byte0 = {opc, target[11:8]}, byte1 = target[7:0].

States (3-bit encoding):
- IDLE: start=1 -> FETCH; otherwise stay.
- FETCH: ir_out<=instr. -> DECODE.
- DECODE, opc 0x0-0xB: -> EXEC, no PC action.
- DECODE, opc 0xC/0xD/0xE: pc_en=1; latch ir_out[3:0] as target high; -> FETCH2.
- DECODE, opc 0xF: pc_en=1, so resume continues at the next address; -> HALT.
- EXEC: exec_en=1 only if opc≠0x0; pc_en=1. Next is HALT if halt_req=1, else FETCH.
- FETCH2: taken = JMP, or (JC & flag_c), or (JZ & flag_z), with flags sampled this cycle.
  - taken: pc_load=1, pc_load_val={target_hi, instr}.
  - not taken: pc_en=1.
  - Next is HALT if halt_req=1, else FETCH.
- HALT: halted=1, PC held. start=1 -> FETCH. halt_req is ignored while halted.

Timing and boundary rules:
- Latency: 3 cycles per one-byte instruction (FETCH, DECODE, EXEC); 3 cycles per jump (FETCH, DECODE, FETCH2).
- halt_req takes effect only at the EXEC/FETCH2 exit. An in-flight instruction always completes, including the PC update.
- PC wrap-around (0xFFF -> 0x000) is the counter's job. A jump whose byte0 sits at 0xFFF takes byte1 from 0x000; no special casing.
- start=1 while busy is ignored.
- start and halt_req both 1 in EXEC: HALT wins.
- Reset mid-instruction aborts it immediately. The PC action of the aborted cycle does not occur.

Decomposition:
- Shared package pc_seq_pkg holds:
  - state localparams S_IDLE..S_HALT;
  - opcode constants OP_NOP, OP_JC, OP_JZ, OP_JMP, OP_HLT, and OP_LAST_DATA=0xB.
- Optional sub-module pc_seq_branch_eval: combinational taken/target computation from opc, flags, target_hi and instr.
- Everything else is flat.

Test Plan:
- Reset, start, ROM = 0x31, 0x00. Expect: 2 cycles after start, exec_en pulses 1 cycle; pc_en pulses in EXEC; ir_out=0x31.
- JMP: PC=0x010 holds 0xE4, 0x56. Expect: DECODE pc_en=1; FETCH2 pc_load=1, pc_load_val=0x456, pc_en=0; next FETCH.
- JZ with flag_z=0, bytes 0xD1, 0x23. Expect: FETCH2 pc_en=1, pc_load=0 (falls through). Repeat with flag_z=1: pc_load=1, pc_load_val=0x123.
- HLT at 0x020. Expect: pc_en pulses once, then halted=1, busy=0, no further pc_en. start=1 -> FETCH at 0x021.
- halt_req=1 asserted during DECODE of data op 0x52. Expect: exec_en still pulses, pc_en pulses, then HALT.
- reset asserted mid-FETCH2 of a taken JMP. Expect: immediately IDLE, all outputs 0, no pc_load; after release, start resumes from FETCH.
